oscillator_period_ctrl: RTL
===========================

OSCILLATOR_PERIOD_CTRL -- requirements
Module: oscillator_period_ctrl

Interface
REQ-001 Parameter PERIOD_INT_PART, default 10, SHALL be the integer bits of the period word.
REQ-002 Parameter PERIOD_FRAC_PART, default 20, SHALL be the fractional bits of the period word; W = PERIOD_INT_PART+PERIOD_FRAC_PART throughout.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 CLK  in  1  parallel-data clock, the single clock of the block.
REQ-005 RESET_N  in  1  asynchronous active-low reset.
REQ-006 CE  in  1  update strobe; slew and oscillator advance occur only when high.
REQ-007 ENABLE  in  1  run request: 1 = oscillator running, 0 = oscillator held in reset.
REQ-008 TARGET_VALID  in  1  new target period offered.
REQ-009 TARGET_READY  out  1  target accepted this cycle when TARGET_VALID also high.
REQ-010 TARGET_PERIOD  in  W  requested period, unsigned fixed point.
REQ-011 MIN_PERIOD, MAX_PERIOD  in  W each  inclusive period limits.
REQ-012 STEP  in  W  maximum period change per CE tick while slewing.
REQ-013 PERIOD_OUT  out  W  period word driven to the oscillator.
REQ-014 OSC_CE  out  1  oscillator clock enable.
REQ-015 OSC_RESET  out  1  active-high oscillator reset.
REQ-016 LOCKED  out  1  high while PERIOD_OUT equals the accepted target and the oscillator runs.
REQ-017 CLAMPED  out  1  one-cycle pulse when an accepted target was limited.

Function
REQ-018 FSM states SHALL be IDLE, START, SLEW, LOCKED.
REQ-019 TARGET_READY SHALL be 1 in IDLE, SLEW and LOCKED, and 0 in START.
REQ-020 On TARGET_VALID & TARGET_READY: target_reg <= max(MIN_PERIOD, min(TARGET_PERIOD, MAX_PERIOD)); has_target <= 1; CLAMPED = 1 on the next cycle iff the result differs from TARGET_PERIOD.
REQ-021 If MIN_PERIOD > MAX_PERIOD, MIN_PERIOD SHALL win, per the REQ-020 formula.
REQ-022 IDLE: OSC_RESET=1, OSC_CE=0, PERIOD_OUT retained; IDLE -> START when ENABLE=1 and has_target=1 (including a target accepted in the same cycle).
REQ-023 START: lasts exactly one cycle; PERIOD_OUT <= target_reg with no slew; OSC_RESET stays 1; next state is LOCKED.
REQ-024 LOCKED: OSC_RESET=0 and OSC_CE=CE. Goes to SLEW when target_reg != PERIOD_OUT.
REQ-025 SLEW: OSC_RESET=0 and OSC_CE=CE.
REQ-026 On each CE=1 in SLEW, PERIOD_OUT SHALL move toward target_reg by min(STEP, |target_reg-PERIOD_OUT|).
REQ-027 SLEW -> LOCKED in the cycle after PERIOD_OUT equals target_reg.
REQ-028 STEP=0 SHALL mean an immediate jump to target_reg on the next CE.
REQ-029 Slew arithmetic SHALL be unsigned W-bit and never overshoot, wrap, or leave [min(target_reg, PERIOD_OUT), max(target_reg, PERIOD_OUT)].
REQ-030 A new target accepted during SLEW SHALL take effect on the following cycle; direction is recomputed and there is no transient reversal beyond one step.
REQ-031 ENABLE=0 in START, SLEW or LOCKED SHALL go to IDLE next cycle; OSC_RESET=1 from that cycle, PERIOD_OUT and target_reg kept.
REQ-032 ENABLE deassert SHALL take priority over slew and lock transitions in the same cycle.
REQ-033 LOCKED output = (state==LOCKED). OSC_RESET, PERIOD_OUT, LOCKED and CLAMPED SHALL be registered; OSC_CE = CE gated by a registered running flag.

Reset
REQ-034 While RESET_N=0: state=IDLE, PERIOD_OUT=0, target_reg=0, has_target=0, OSC_RESET=1, OSC_CE=0, TARGET_READY=0, LOCKED=0, CLAMPED=0.
REQ-035 Reset asserted mid-slew SHALL abort immediately and asynchronously, with no handshake completed in that cycle.
REQ-036 After release, the first accepted target SHALL be required before START.

Structure
REQ-037 Package osc_ctrl_pkg SHALL hold the FSM state enum and the default PERIOD_INT_PART/PERIOD_FRAC_PART constants.
REQ-038 Sub-module period_clamp SHALL be combinational, with inputs value, min, max and outputs clamped value and clamp flag; it is instanced once.

Verification
REQ-039 Reset release, target 0x0A000000, ENABLE=1 -> START one cycle; PERIOD_OUT=0x0A000000 on the next cycle with OSC_RESET=0 and LOCKED=1.
REQ-040 Locked at 0x0A000000, new target 0x0A000100, STEP=0x40, CE every cycle -> PERIOD_OUT goes 0x0A000040, 0x080, 0x0C0, 0x100, then LOCKED=1 one cycle later.
REQ-041 MIN=0x01000000, MAX=0x20000000, target 0x30000000 -> target_reg=0x20000000 and a CLAMPED pulse. Target 0x10000000 -> no CLAMPED pulse.
REQ-042 Slewing up with remaining difference 0x30, STEP=0x40 -> final step 0x30, no overshoot. New lower target mid-slew -> direction reverses the next cycle.
REQ-043 ENABLE=0 mid-slew -> OSC_RESET=1 next cycle and PERIOD_OUT held. ENABLE=1 again -> START loads target_reg directly.
REQ-044 RESET_N pulsed low mid-slew -> all outputs take their reset values asynchronously, and TARGET_READY=0 during reset.

Source files
------------

// File: rtl/osc_ctrl_pkg.sv
// ============================================================================
// Module  : osc_ctrl_pkg
// Brief   : Shared FSM encoding and default period-word widths.
// Revision: 1.0
// ============================================================================
`default_nettype none

package osc_ctrl_pkg;

  localparam int unsigned C_PERIOD_INT_PART  = 10;
  localparam int unsigned C_PERIOD_FRAC_PART = 20;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_START  = 2'd1,
    ST_SLEW   = 2'd2,
    ST_LOCKED = 2'd3
  } osc_state_e;

endpackage

`default_nettype wire

// File: rtl/period_clamp.sv
// ============================================================================
// Module  : period_clamp
// Brief   : Limits a period word to [min, max]; min wins when min > max.
// Revision: 1.0
// ============================================================================
`default_nettype none

module period_clamp #(
  parameter int unsigned W = 30
) (
  input  logic [W-1:0] value_i,
  input  logic [W-1:0] min_i,
  input  logic [W-1:0] max_i,
  output logic [W-1:0] clamped_o,
  output logic         flag_o
);

  logic [W-1:0] w_upper;

  assign w_upper   = (value_i > max_i) ? max_i : value_i;
  assign clamped_o = (w_upper < min_i) ? min_i : w_upper;
  assign flag_o    = (clamped_o != value_i);

endmodule

`default_nettype wire

// File: rtl/oscillator_period_ctrl.sv
// ============================================================================
// Module  : oscillator_period_ctrl
// Brief   : Accepts a target period, slews the oscillator period word toward it.
// Revision: 1.0
// ============================================================================
`default_nettype none

module oscillator_period_ctrl
  import osc_ctrl_pkg::*;
#(
  parameter int unsigned PERIOD_INT_PART  = C_PERIOD_INT_PART,
  parameter int unsigned PERIOD_FRAC_PART = C_PERIOD_FRAC_PART
) (
  input  logic                                      clk_i,
  input  logic                                      reset_n_i,
  input  logic                                      ce_i,
  input  logic                                      enable_i,
  input  logic                                      target_valid_i,
  output logic                                      target_ready_o,
  input  logic [PERIOD_INT_PART+PERIOD_FRAC_PART-1:0] target_period_i,
  input  logic [PERIOD_INT_PART+PERIOD_FRAC_PART-1:0] min_period_i,
  input  logic [PERIOD_INT_PART+PERIOD_FRAC_PART-1:0] max_period_i,
  input  logic [PERIOD_INT_PART+PERIOD_FRAC_PART-1:0] step_i,
  output logic [PERIOD_INT_PART+PERIOD_FRAC_PART-1:0] period_out_o,
  output logic                                      osc_ce_o,
  output logic                                      osc_reset_o,
  output logic                                      locked_o,
  output logic                                      clamped_o
);

  localparam int unsigned W = PERIOD_INT_PART + PERIOD_FRAC_PART;

  osc_state_e   state_q, state_d;
  logic [W-1:0] period_q, period_d;
  logic [W-1:0] target_q, target_d;
  logic         has_target_q, has_target_d;
  logic         ready_q, running_q, osc_reset_q, locked_q, clamped_q;

  logic [W-1:0] w_clamp_val;
  logic         w_clamp_flag;
  logic         w_accept;
  logic         w_up;
  logic [W-1:0] w_diff, w_delta, w_slew_next;

  period_clamp #(.W(W)) u_clamp (
    .value_i   (target_period_i),
    .min_i     (min_period_i),
    .max_i     (max_period_i),
    .clamped_o (w_clamp_val),
    .flag_o    (w_clamp_flag)
  );

  assign w_accept = target_valid_i & ready_q;

  // Step is limited to the remaining distance, so the word never overshoots or wraps.
  assign w_up        = (target_q > period_q);
  assign w_diff      = w_up ? (target_q - period_q) : (period_q - target_q);
  assign w_delta     = ((step_i == '0) || (step_i > w_diff)) ? w_diff : step_i;
  assign w_slew_next = w_up ? (period_q + w_delta) : (period_q - w_delta);

  always_comb begin
    state_d      = state_q;
    period_d     = period_q;
    target_d     = target_q;
    has_target_d = has_target_q;
    if (w_accept) begin
      target_d     = w_clamp_val;
      has_target_d = 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        if (enable_i && (has_target_q || w_accept)) state_d = ST_START;
      end
      ST_START: begin
        if (!enable_i) begin
          state_d = ST_IDLE;
        end else begin
          period_d = target_q;
          state_d  = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (!enable_i)                  state_d = ST_IDLE;
        else if (target_q != period_q)  state_d = ST_SLEW;
      end
      ST_SLEW: begin
        if (!enable_i)                  state_d = ST_IDLE;
        else if (period_q == target_q)  state_d = ST_LOCKED;
        else if (ce_i)                  period_d = w_slew_next;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= ST_IDLE;
      period_q     <= '0;
      target_q     <= '0;
      has_target_q <= 1'b0;
      ready_q      <= 1'b0;
      running_q    <= 1'b0;
      osc_reset_q  <= 1'b1;
      locked_q     <= 1'b0;
      clamped_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_q     <= period_d;
      target_q     <= target_d;
      has_target_q <= has_target_d;
      ready_q      <= (state_d != ST_START);
      running_q    <= (state_d == ST_SLEW) || (state_d == ST_LOCKED);
      osc_reset_q  <= (state_d == ST_IDLE) || (state_d == ST_START);
      locked_q     <= (state_d == ST_LOCKED);
      clamped_q    <= w_accept & w_clamp_flag;
    end
  end

  assign target_ready_o = ready_q;
  assign period_out_o   = period_q;
  assign osc_ce_o       = ce_i & running_q;
  assign osc_reset_o    = osc_reset_q;
  assign locked_o       = locked_q;
  assign clamped_o      = clamped_q;

endmodule

`default_nettype wire
